// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: restoring shift-subtract divider with sign fix-up,
// pipeline stall handshake and flush abort. Result is {remainder, quotient}.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               flush,
  output logic               ex_stall,
  output logic               done,
  output logic [2*WIDTH-1:0] WHILO_Data
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t r_state, w_next_state;

  logic [WIDTH-1:0]   r_a, r_b, r_q, r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_signed, r_qs, r_rs;
  logic [2*WIDTH-1:0] r_whilo;

  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q_fix, w_r_fix;
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_fits, w_last;

  assign w_abs_a = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Partial remainder stays below the divisor, so the 33-bit shifted value minus the
  // divisor has its top bit set exactly when the subtraction would go negative.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_fits  = ~w_diff[WIDTH];
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign w_q_fix = (r_signed && r_qs) ? -r_q   : r_q;
  assign w_r_fix = (r_signed && r_rs) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_PREP;
      S_PREP:  w_next_state = (r_b == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_qs     <= 1'b0;
      r_rs     <= 1'b0;
      r_whilo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_a      <= dividend;
            r_b      <= divisor;
            r_signed <= signed_op;
          end
        end
        S_PREP: begin
          r_q   <= w_abs_a;
          r_b   <= w_abs_b;
          r_rem <= '0;
          r_cnt <= '0;
          r_qs  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_rs  <= r_a[WIDTH-1];
          // Divide-by-zero completes here with the raw dividend as remainder.
          if (r_b == '0 && !flush) r_whilo <= {r_a, {WIDTH{1'b1}}};
        end
        S_RUN: begin
          r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          if (!flush) r_whilo <= {w_r_fix, w_q_fix};
        end
        default: ;
      endcase
    end
  end

  assign ex_stall   = !flush && ((r_state == S_IDLE && start) ||
                                 (r_state inside {S_PREP, S_RUN, S_FIX}));
  assign done       = (r_state == S_DONE);
  assign WHILO_Data = r_whilo;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall profile, signed/unsigned results,
// divide-by-zero, flush and reset aborts, back-to-back issue.
module tb_div_sequencer;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset, start, signed_op, flush;
  logic [W-1:0]   dividend, divisor;
  logic           ex_stall, done;
  logic [2*W-1:0] WHILO_Data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .done       (done),
    .WHILO_Data (WHILO_Data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op at cycle 0, holds start until done, and checks the stall profile,
  // the done cycle and the result.
  task automatic run_op(input string name, input logic sop, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_data,
                        input int lat, input bit flush_in_done);
    int done_at   = -1;
    int stall_err = 0;
    signed_op = sop; dividend = a; divisor = b; start = 1'b1;
    for (int cyc = 0; cyc <= lat + 4 && done_at < 0; cyc++) begin
      if (flush_in_done && cyc == lat) flush = 1'b1;
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = cyc;
        total_cnt++;
        if (WHILO_Data !== exp_data)
          $display("FAIL %s_data got %h want %h", name, WHILO_Data, exp_data);
        else pass_cnt++;
        total_cnt++;
        if (ex_stall !== 1'b0)
          $display("FAIL %s_stall_in_done got %b want 0", name, ex_stall);
        else pass_cnt++;
      end else if (ex_stall !== 1'b1) begin
        stall_err++;
      end
      tick();
    end
    start = 1'b0;
    flush = 1'b0;
    total_cnt++;
    if (done_at != lat) $display("FAIL %s_done_cycle got %0d want %0d", name, done_at, lat);
    else pass_cnt++;
    total_cnt++;
    if (stall_err != 0) $display("FAIL %s_stall_profile got %0d bad cycles want 0", name, stall_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; flush = 1'b0; signed_op = 1'b0;
    dividend = '1; divisor = 32'd1;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ex_stall !== 1'b0) $display("FAIL reset_ex_stall got %b want 0", ex_stall); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++;
    if (WHILO_Data !== 64'd0) $display("FAIL reset_whilo got %h want 0", WHILO_Data); else pass_cnt++;
    tick();
  endtask

  // Start is held through DONE, so afterwards no second op may launch.
  task automatic test_divu_basic();
    int extra = 0;
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 35, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || ex_stall !== 1'b0) extra++;
      tick();
    end
    total_cnt++;
    if (extra != 0) $display("FAIL no_restart got %0d active cycles want 0", extra); else pass_cnt++;
  endtask

  task automatic test_div_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 35, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 35, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0000_0000, 32'hFFFF_FFFF}, 35, 1'b0);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, 2, 1'b0);
    run_op("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 1'b0, 32'd1000, 32'd10, {32'h0000_0000, 32'h0000_0064}, 35, 1'b0);
    run_op("b2b_second", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 35, 1'b0);
  endtask

  task automatic test_flush_mid_run();
    int pulses = 0;
    int stalls = 0;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ex_stall !== 1'b0) $display("FAIL flush_cycle_stall got %b want 0", ex_stall); else pass_cnt++;
    tick();
    flush = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (ex_stall !== 1'b0) stalls++;
      tick();
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL flush_no_done got %0d pulses want 0", pulses); else pass_cnt++;
    total_cnt++;
    if (stalls != 0) $display("FAIL flush_idle got %0d stall cycles want 0", stalls); else pass_cnt++;
    total_cnt++;
    if (WHILO_Data !== {32'h0000_0001, 32'hFFFF_FFFD})
      $display("FAIL flush_whilo_kept got %h want %h", WHILO_Data, {32'h0000_0001, 32'hFFFF_FFFD});
    else pass_cnt++;
    run_op("restart_9_4", 1'b0, 32'd9, 32'd4, {32'h0000_0001, 32'h0000_0002}, 35, 1'b0);
  endtask

  task automatic test_flush_start_idle();
    int bad = 0;
    signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ex_stall !== 1'b0) $display("FAIL flush_start_stall got %b want 0", ex_stall); else pass_cnt++;
    tick();
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ex_stall !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    total_cnt++;
    if (bad != 0) $display("FAIL flush_start_ignored got %0d active cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_flush_in_done();
    run_op("flush_done", 1'b0, 32'd1000, 32'd10, {32'h0000_0000, 32'h0000_0064}, 35, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || ex_stall !== 1'b0)
      $display("FAIL flush_done_idle got done=%b stall=%b want 0/0", done, ex_stall);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    signed_op = 1'b1; dividend = 32'hFFFF_FFF0; divisor = 32'd3; start = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ex_stall !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_run_ctrl got done=%b stall=%b want 0/0", done, ex_stall);
    else pass_cnt++;
    total_cnt++;
    if (WHILO_Data !== 64'd0) $display("FAIL rst_run_whilo got %h want 0", WHILO_Data); else pass_cnt++;
    tick();
    run_op("div_m16_3", 1'b1, 32'hFFFF_FFF0, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 35, 1'b0);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_by_zero();
    test_back_to_back();
    test_flush_mid_run();
    test_flush_start_idle();
    test_flush_in_done();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
